reg_file: RTL

- Integer register file for the RV32I single-cycle datapath. It sits directly upstream of the ALU.
- RD1 drives SrcA. RD2 drives SrcB (via the immediate mux).
- The writeback value, WD3 (ALUResult or load data), returns on the write port.
- Two combinational read ports and one synchronous write port. x0 is hardwired to zero.
- A post-reset clear sequencer zeroes x1..x31 one register per cycle, so storage needs no per-bit reset and maps to distributed RAM.

---
 rtl/reg_file.sv | 74 +++++++
 1 files changed

// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero, post-reset clear sequencer. Optional macro REGFILE_BYPASS_EN adds write-through bypass.
module reg_file #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [WIDTH-1:0]      WD3,
  input  logic                  WE3,
  output logic [WIDTH-1:0]      RD1,
  output logic [WIDTH-1:0]      RD2,
  output logic                  Ready
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [WIDTH-1:0]      mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= ADDR_WIDTH'(1);
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_idx <= clr_idx + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_idx == '1) state_next = RUN;
  end

  assign Ready = (state == RUN);

  // Storage has no reset of its own; the sequencer owns the write port until Ready.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_idx] <= '0;
      else if (WE3 && A3 != '0)
        mem[A3] <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    if (Ready && A1 != '0) begin
      RD1 = mem[A1];
`ifdef REGFILE_BYPASS_EN
      if (WE3 && A3 == A1) RD1 = WD3;
`endif
    end
  end

  always_comb begin
    RD2 = '0;
    if (Ready && A2 != '0) begin
      RD2 = mem[A2];
`ifdef REGFILE_BYPASS_EN
      if (WE3 && A3 == A2) RD2 = WD3;
`endif
    end
  end

endmodule
